// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register specifier width, forwarding select codes,
// mult/div latency default and the ID-stage hazard term bundle.
package pipeline_pkg;

   localparam int REG_ADDR_W     = 5;
   localparam int MULDIV_LAT_DEF = 4;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   // Forwarding mux selects, shared with the EX forwarding unit
   localparam logic [1:0] FWD_NONE    = 2'b00;
   localparam logic [1:0] FWD_EX_MEM  = 2'b10;
   localparam logic [1:0] FWD_WB_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB_ALU  = 2'b11;

   typedef struct packed {
      logic loadUse;
      logic brEx;
      logic brMem;
      logic mdConflict;
   } hazard_t;

   function automatic logic anyHazard(input hazard_t h);
      return h.loadUse | h.brEx | h.brMem | h.mdConflict;
   endfunction

endpackage

// File: rtl/muldiv_busy_counter.sv
// Mult/div EX occupancy counter: loads MULDIV_LAT-1 on issue, then counts down
// one per clock and holds at zero. busy is combinational from the count.
module muldiv_busy_counter #(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   output logic             busy,
   output logic [CNT_W-1:0] mdCnt
);
   import pipeline_pkg::*;

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LAT - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         mdCnt <= '0;
      end else if (load) begin
         mdCnt <= LOAD_VAL;
      end else if (mdCnt != '0) begin
         mdCnt <= mdCnt - 1'b1;
      end
   end

   assign busy = (mdCnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection: load-use, unforwardable branch operands, mult/div occupancy.
// Zero-cycle: PC/IF_ID enables and flushes follow the hazard in the same cycle; stall holds IF/ID.
// HAZARD_PERF_CNT_EN adds StallCycles/BranchStallCycles counters without changing behaviour.
module hazard_stall_unit #(
   parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
   parameter int MULDIV_LAT = pipeline_pkg::MULDIV_LAT_DEF,
   parameter int CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] IF_IDRegisterRs,
   input  logic [REG_ADDR_W-1:0] IF_IDRegisterRt,
   input  logic                  IF_IDUsesRt,
   input  logic                  IF_IDIsBranch,
   input  logic                  IF_IDIsMulDiv,
   input  logic                  ID_ExMemRead,
   input  logic                  ID_ExRegWrite,
   input  logic [REG_ADDR_W-1:0] ID_ExRegisterRd,
   input  logic                  Ex_MemMemRead,
   input  logic [REG_ADDR_W-1:0] Ex_MemRegisterRd,
   input  logic                  BranchTaken,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]           StallCycles,
   output logic [31:0]           BranchStallCycles,
`endif
   output logic                  PCWrite,
   output logic                  IF_IDWrite,
   output logic                  ID_ExFlush,
   output logic                  IF_IDFlush
);
   import pipeline_pkg::*;

   hazard_t          hz;
   logic             stall;
   logic             busy;
   logic             mdLoad;
   logic [CNT_W-1:0] mdCnt;

   // $0 is hardwired, so a write to it can never be a real dependency
   function automatic logic regMatch(input logic [REG_ADDR_W-1:0] dst);
      return (dst != REG_ADDR_W'(REG_ZERO)) &&
             ((dst == IF_IDRegisterRs) || (IF_IDUsesRt && (dst == IF_IDRegisterRt)));
   endfunction

   always_comb begin
      hz            = '0;
      hz.loadUse    = ID_ExMemRead && regMatch(ID_ExRegisterRd);
      hz.brEx       = IF_IDIsBranch && ID_ExRegWrite && regMatch(ID_ExRegisterRd);
      hz.brMem      = IF_IDIsBranch && Ex_MemMemRead && regMatch(Ex_MemRegisterRd);
      hz.mdConflict = busy && IF_IDIsMulDiv;
      stall         = anyHazard(hz);
   end

   // A mult/div only claims the unit on the cycle it actually leaves ID
   assign mdLoad = IF_IDIsMulDiv && !stall && !busy;

   muldiv_busy_counter #(
      .MULDIV_LAT (MULDIV_LAT),
      .CNT_W      (CNT_W)
   ) u_busyCnt (
      .clk   (clk),
      .reset (reset),
      .load  (mdLoad),
      .busy  (busy),
      .mdCnt (mdCnt)
   );

   always_comb begin
      PCWrite    = 1'b1;
      IF_IDWrite = 1'b1;
      ID_ExFlush = 1'b0;
      IF_IDFlush = 1'b0;
      if (reset) begin
         PCWrite    = 1'b0;
         IF_IDWrite = 1'b0;
         ID_ExFlush = 1'b1;
         IF_IDFlush = 1'b1;
      end else begin
         PCWrite    = !stall;
         IF_IDWrite = !stall;
         ID_ExFlush = stall;
         // Comparator operands are stale while stalled, so the outcome is ignored
         IF_IDFlush = IF_IDIsBranch && BranchTaken && !stall;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCycles       <= '0;
         BranchStallCycles <= '0;
      end else begin
         if (stall) begin
            StallCycles <= StallCycles + 32'd1;
         end
         if (hz.brEx || hz.brMem) begin
            BranchStallCycles <= BranchStallCycles + 32'd1;
         end
      end
   end
`endif

endmodule
